// File: rtl/mux_scan_pkg.sv
// ============================================================================
// Module  : mux_scan_pkg
// Brief   : Shared types for the mux scan sequencer (state, entry layout).
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

package mux_scan_pkg;

    localparam int CH_W = 6;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SETTLE  = 2'd1,
        CAPTURE = 2'd2,
        DRAIN   = 2'd3
    } state_e;

    typedef struct packed {
        logic            last;
        logic [CH_W-1:0] ch;
        logic [7:0]      data;
    } fifo_entry_t;

endpackage

`default_nettype wire

// File: rtl/mux_scan_fifo.sv
// ============================================================================
// Module  : mux_scan_fifo
// Brief   : Synchronous capture FIFO, wrap-bit pointers, head shown directly.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module mux_scan_fifo #(
    parameter int WIDTH = 15,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             do_wr;
    logic             do_rd;

    // Full is judged on the current pointers, so a same-cycle pop cannot
    // make room for a push.
    always_comb begin
        empty    = (wr_ptr_q == rd_ptr_q);
        full     = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
        do_wr    = wr_en && !full;
        do_rd    = rd_en && !empty;
        wr_ptr_d = do_wr ? wr_ptr_q + (AW+1)'(1) : wr_ptr_q;
        rd_ptr_d = do_rd ? rd_ptr_q + (AW+1)'(1) : rd_ptr_q;
        rd_data  = mem_q[rd_ptr_q[AW-1:0]];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            if (do_wr) begin
                mem_q[wr_ptr_q[AW-1:0]] <= wr_data;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/mux_scan_sequencer.sv
// ============================================================================
// Module  : mux_scan_sequencer
// Brief   : Steps the byte-mux select over all channels, captures each byte
//           after a settle delay and streams {last, ch, data} downstream.
//           Define MUX_SCAN_LOOP_EN for continuous scanning with stop request.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module mux_scan_sequencer
    import mux_scan_pkg::*;
#(
    parameter int NUM_CH     = 40,
    parameter int DATA_W     = 8,
    parameter int SEL_W      = 16,
    parameter int SETTLE_CYC = 1,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    output logic [SEL_W-1:0]  outselect,
    input  logic [DATA_W-1:0] muxout,
    output logic [DATA_W-1:0] out_data,
    output logic [CH_W-1:0]   out_ch,
    output logic              out_last,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              busy,
    output logic              done
);

    localparam int         EW         = 1 + CH_W + DATA_W;
    localparam logic [3:0] c_cnt_load = 4'(SETTLE_CYC - 1);
    localparam logic [CH_W-1:0] c_last_ch = CH_W'(NUM_CH - 1);

    state_e           state_q, state_d;
    logic [CH_W-1:0]  ch_q, ch_d;
    logic [3:0]       cnt_q, cnt_d;
    logic [SEL_W-1:0] sel_q, sel_d;
`ifdef MUX_SCAN_LOOP_EN
    logic             stop_q, stop_d;
`endif

    logic             fifo_wr;
    logic             fifo_full;
    logic             fifo_empty;
    logic [EW-1:0]    fifo_head;
    logic             at_last_ch;

    assign at_last_ch = (ch_q == c_last_ch);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            ch_q    <= '0;
            cnt_q   <= '0;
            sel_q   <= '0;
`ifdef MUX_SCAN_LOOP_EN
            stop_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            ch_q    <= ch_d;
            cnt_q   <= cnt_d;
            sel_q   <= sel_d;
`ifdef MUX_SCAN_LOOP_EN
            stop_q  <= stop_d;
`endif
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        ch_d    = ch_q;
        cnt_d   = cnt_q;
        sel_d   = sel_q;
`ifdef MUX_SCAN_LOOP_EN
        stop_d  = stop_q;
        if (start && (state_q == SETTLE || state_q == CAPTURE)) begin
            stop_d = 1'b1;
        end
`endif
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    ch_d    = '0;
                    sel_d   = '0;
                    cnt_d   = c_cnt_load;
                    state_d = SETTLE;
`ifdef MUX_SCAN_LOOP_EN
                    stop_d  = 1'b0;
`endif
                end
            end
            SETTLE: begin
                if (cnt_q == 4'd0) begin
                    state_d = CAPTURE;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            CAPTURE: begin
                // A full FIFO stalls here with the select held steady.
                if (!fifo_full) begin
                    if (at_last_ch) begin
`ifdef MUX_SCAN_LOOP_EN
                        if (stop_q || start) begin
                            state_d = DRAIN;
                        end else begin
                            ch_d    = '0;
                            sel_d   = '0;
                            cnt_d   = c_cnt_load;
                            state_d = SETTLE;
                        end
`else
                        state_d = DRAIN;
`endif
                    end else begin
                        ch_d    = ch_q + CH_W'(1);
                        sel_d   = SEL_W'(ch_q + CH_W'(1));
                        cnt_d   = c_cnt_load;
                        state_d = SETTLE;
                    end
                end
            end
            DRAIN: begin
                if (fifo_empty) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        busy      = (state_q != IDLE);
        done      = (state_q == DRAIN) && fifo_empty;
        fifo_wr   = (state_q == CAPTURE) && !fifo_full;
        outselect = sel_q;
    end

    mux_scan_fifo #(
        .WIDTH (EW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (fifo_wr),
        .wr_data ({at_last_ch, ch_q, muxout}),
        .rd_en   (out_ready),
        .rd_data (fifo_head),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    assign out_valid = !fifo_empty;
    assign out_last  = fifo_head[EW-1];
    assign out_ch    = fifo_head[DATA_W +: CH_W];
    assign out_data  = fifo_head[DATA_W-1:0];

endmodule

`default_nettype wire

// File: tb/tb_mux_scan_sequencer.sv
// ============================================================================
// Module  : tb_mux_scan_sequencer
// Brief   : Scoreboard bench: frames of random mux bytes with a 2-cycle mux.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_mux_scan_sequencer;
    import mux_scan_pkg::*;

    localparam int NUM_CH     = 40;
    localparam int DATA_W     = 8;
    localparam int SEL_W      = 16;
    localparam int SETTLE_CYC = 3;
    localparam int FIFO_DEPTH = 4;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              start = 1'b0;
    logic [SEL_W-1:0]  outselect;
    logic [DATA_W-1:0] muxout;
    logic [DATA_W-1:0] out_data;
    logic [CH_W-1:0]   out_ch;
    logic              out_last;
    logic              out_valid;
    logic              out_ready = 1'b0;
    logic              busy;
    logic              done;

    int vectors     = 0;
    int miscompares = 0;
    int done_cnt    = 0;
    int pops        = 0;
    int ready_mode  = 0;
    bit expect_done = 1'b0;

    fifo_entry_t exp_q[$];
    logic [7:0]  mux_tbl [NUM_CH];

    always #5 clk = ~clk;

    mux_scan_sequencer #(
        .NUM_CH     (NUM_CH),
        .DATA_W     (DATA_W),
        .SEL_W      (SEL_W),
        .SETTLE_CYC (SETTLE_CYC),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .outselect (outselect),
        .muxout    (muxout),
        .out_data  (out_data),
        .out_ch    (out_ch),
        .out_last  (out_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .busy      (busy),
        .done      (done)
    );

    // Mux whose output follows the select two cycles late.
    logic [SEL_W-1:0] sel_p1 = '0;
    logic [SEL_W-1:0] sel_p2 = '0;
    always @(posedge clk) begin
        sel_p1 <= outselect;
        sel_p2 <= sel_p1;
    end
    always_comb begin
        muxout = 8'h00;
        if (sel_p2 < SEL_W'(NUM_CH)) muxout = mux_tbl[sel_p2[5:0]];
    end

    function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endfunction

    // Expected frame: channel k returns its table byte, last only on the top channel.
    function automatic void push_frame(bit new_table);
        fifo_entry_t e;
        for (int k = 0; k < NUM_CH; k++) begin
            if (new_table) mux_tbl[k] = 8'($urandom);
            e.last = (k == NUM_CH - 1);
            e.ch   = CH_W'(k);
            e.data = mux_tbl[k];
            exp_q.push_back(e);
        end
    endfunction

    initial begin
        forever begin
            @(posedge clk);
            #1;
            case (ready_mode)
                0:       out_ready = 1'b1;
                1:       out_ready = 1'($urandom_range(0, 1));
                default: out_ready = 1'b0;
            endcase
        end
    end

    // Monitor / scoreboard
    bit          hold_prev = 1'b0;
    logic [14:0] prev_head = '0;
    always @(negedge clk) begin
        if (!rst_n) begin
            hold_prev = 1'b0;
        end else begin
            check("outselect_range", 32'(outselect < SEL_W'(NUM_CH)), 1);
            if (hold_prev) begin
                check("hold_valid", 32'(out_valid), 1);
                check("hold_head", 32'({out_last, out_ch, out_data}), 32'(prev_head));
            end
            if (out_valid && out_ready) begin
                check("beat_expected", 32'(exp_q.size() != 0), 1);
                if (exp_q.size() != 0) begin
                    fifo_entry_t e;
                    e = exp_q.pop_front();
                    check("beat_data", 32'(out_data), 32'(e.data));
                    check("beat_ch",   32'(out_ch),   32'(e.ch));
                    check("beat_last", 32'(out_last), 32'(e.last));
                end
                pops++;
            end
            hold_prev = out_valid && !out_ready;
            prev_head = {out_last, out_ch, out_data};
            if (done) begin
                check("done_expected", 32'(expect_done), 1);
                check("done_queue_empty", 32'(exp_q.size()), 0);
                expect_done = 1'b0;
                done_cnt++;
            end
        end
    end

    task automatic cyc(int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic wait_done(int budget);
        int c0 = done_cnt;
        int n  = 0;
        while (done_cnt == c0 && n < budget) begin
            cyc(1);
            n++;
        end
        check("done_seen", 32'(done_cnt - c0), 1);
        cyc(1);
        check("busy_after_done", 32'(busy), 0);
    endtask

    task automatic wait_sel(int sel, int budget);
        int n = 0;
        while (outselect != SEL_W'(sel) && n < budget) begin
            cyc(1);
            n++;
        end
        check("reach_select", 32'(outselect), 32'(sel));
    endtask

    task automatic check_reset_values();
        check("rst_outselect", 32'(outselect), 0);
        check("rst_out_valid", 32'(out_valid), 0);
        check("rst_out_data",  32'(out_data),  0);
        check("rst_out_ch",    32'(out_ch),    0);
        check("rst_out_last",  32'(out_last),  0);
        check("rst_busy",      32'(busy),      0);
        check("rst_done",      32'(done),      0);
    endtask

    initial begin
        int n;
        int dc;
        for (int k = 0; k < NUM_CH; k++) mux_tbl[k] = 8'(k + 8'h10);

        rst_n = 1'b0;
        cyc(3);
        check_reset_values();
        rst_n = 1'b1;
        cyc(1);

        // Basic frame: latency from the start edge to out_valid.
        ready_mode  = 0;
        push_frame(1'b0);
        expect_done = 1'b1;
        pulse_start();
        check("busy_after_start", 32'(busy), 1);
        n = 0;
        while (!out_valid && n < 50) begin
            cyc(1);
            n++;
        end
        check("start_to_valid", 32'(n), 32'(SETTLE_CYC + 1));
        wait_done(1000);

        // Backpressure: FIFO fills and the select freezes at channel 4.
        ready_mode  = 2;
        push_frame(1'b1);
        expect_done = 1'b1;
        pulse_start();
        cyc(30);
        check("bp_outselect", 32'(outselect), 4);
        check("bp_valid", 32'(out_valid), 1);
        check("bp_head_ch", 32'(out_ch), 0);
        cyc(5);
        check("bp_outselect_held", 32'(outselect), 4);
        ready_mode = 1;
        wait_done(5000);
        check("bp_queue_drained", 32'(exp_q.size()), 0);

        // Start while busy is ignored.
        ready_mode  = 1;
        push_frame(1'b1);
        expect_done = 1'b1;
        pulse_start();
        wait_sel(10, 2000);
        pulse_start();
        wait_done(5000);
        dc = done_cnt;
        cyc(40);
        check("no_second_frame_valid", 32'(out_valid), 0);
        check("no_second_done", 32'(done_cnt), 32'(dc));
        check("no_extra_beats", 32'(exp_q.size()), 0);

        // Reset mid-frame.
        ready_mode  = 1;
        push_frame(1'b1);
        expect_done = 1'b1;
        pulse_start();
        wait_sel(17, 2000);
        rst_n = 1'b0;
        #1;
        check_reset_values();
        exp_q.delete();
        expect_done = 1'b0;
        cyc(2);
        rst_n = 1'b1;
        cyc(1);
        push_frame(1'b1);
        expect_done = 1'b1;
        pulse_start();
        wait_done(5000);

        // Extra random frames.
        for (int f = 0; f < 2; f++) begin
            ready_mode  = (f == 0) ? 0 : 1;
            push_frame(1'b1);
            expect_done = 1'b1;
            pulse_start();
            wait_done(5000);
        end

`ifdef MUX_SCAN_LOOP_EN
        // Continuous scanning: two wraps, stop request in the third frame.
        ready_mode = 0;
        push_frame(1'b1);
        push_frame(1'b0);
        push_frame(1'b0);
        n = pops;
        pulse_start();
        dc = 0;
        while (pops < n + 2 * NUM_CH + 5 && dc < 5000) begin
            cyc(1);
            dc++;
        end
        check("loop_third_frame_reached", 32'(pops >= n + 2 * NUM_CH + 5), 1);
        expect_done = 1'b1;
        pulse_start();
        wait_done(2000);
        check("loop_all_beats", 32'(pops - n), 32'(3 * NUM_CH));
`endif

        check("final_queue_empty", 32'(exp_q.size()), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

`default_nettype wire
